// File: rtl/midi_byte_decoder_if.sv
// -----------------------------------------------------------------------------
// midi_byte_decoder_if
//
// Purpose: groups the signals between the UART receiver side, the MIDI byte
// decoder and the downstream sequence trigger stage.
//
// Signals:
//   rx_data        [7:0] received MIDI byte
//   rx_valid             one-cycle strobe, rx_data valid
//   sel_midi_ch    [3:0] channel this synth listens on
//   omni                 1 = accept every channel
//   byteready            one-cycle pulse per accepted byte
//   midibyte_nr    [7:0] position of byte in message (status = 0)
//   midi_in_data   [7:0] accepted byte
//   midi_ch        [3:0] channel of current channel-voice status
//   is_cur_midi_ch       current message is for this synth
//   is_st_sysex          inside a sysex message
//   status_byte    [7:0] latched running status (0 = none)
//   rt_valid             one-cycle pulse for a real-time byte
//   rt_byte        [7:0] the real-time byte
//   drop_cnt       [7:0] discarded data bytes, saturating
//
// Modports:
//   master - the side that supplies bytes and configuration and consumes
//            the decoded stream
//   slave  - the decoder itself
// -----------------------------------------------------------------------------
interface midi_byte_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] sel_midi_ch;
  logic       omni;
  logic       byteready;
  logic [7:0] midibyte_nr;
  logic [7:0] midi_in_data;
  logic [3:0] midi_ch;
  logic       is_cur_midi_ch;
  logic       is_st_sysex;
  logic [7:0] status_byte;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic [7:0] drop_cnt;

  modport master (
    output rx_data, rx_valid, sel_midi_ch, omni,
    input  byteready, midibyte_nr, midi_in_data, midi_ch, is_cur_midi_ch,
           is_st_sysex, status_byte, rt_valid, rt_byte, drop_cnt
  );

  modport slave (
    input  rx_data, rx_valid, sel_midi_ch, omni,
    output byteready, midibyte_nr, midi_in_data, midi_ch, is_cur_midi_ch,
           is_st_sysex, status_byte, rt_valid, rt_byte, drop_cnt
  );
endinterface

// File: rtl/midi_byte_decoder.sv
// -----------------------------------------------------------------------------
// midi_byte_decoder
//
// Purpose: classifies raw MIDI bytes from the UART receiver, tracks status and
// running status, numbers each byte within its message and tags it with its
// channel / sysex context. Every output is registered with one cycle latency.
//
// Ports:
//   reg_clk    system register clock
//   reset_reg  asynchronous, active-high reset; clears every register
//   bus        midi_byte_decoder_if.slave (rx byte in, decoded stream out)
//
// Parameters:
//   SYX_MAX_NR  saturation value of midibyte_nr inside sysex
//   NR_WRAP     last midibyte_nr of a 2-data running-status stream; the next
//               data byte restarts at 1 so odd = first, even = second byte
// -----------------------------------------------------------------------------
module midi_byte_decoder #(
  parameter logic [7:0] SYX_MAX_NR = 8'd255,
  parameter logic [7:0] NR_WRAP    = 8'd254
) (
  input  logic                reg_clk,
  input  logic                reset_reg,
  midi_byte_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,   // no running status, data bytes discarded
    CHAN,   // channel-voice running status
    SYSEX,  // inside a system exclusive message
    COMMON  // system common message, data bytes discarded
  } state_t;

  state_t     state_q, state_d;
  logic       byteready_q, byteready_d;
  logic [7:0] nr_q, nr_d;
  logic [7:0] data_q, data_d;
  logic [3:0] ch_q, ch_d;
  logic       cur_q, cur_d;
  logic       sysex_q, sysex_d;
  logic [7:0] status_q, status_d;
  logic       rt_valid_q, rt_valid_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic [7:0] drop_q, drop_d;
  // Set by the F7 that closes a sysex: is_st_sysex stays high on the F7
  // pulse itself and drops one cycle later.
  logic       sysex_end_q, sysex_end_d;

  // Byte classes
  logic is_rt, is_data, is_chan_status, is_f0, is_f7;
  logic two_data;
  logic [7:0] nr_sat_inc;

  assign is_rt          = &bus.rx_data[7:3];                  // F8-FF
  assign is_data        = ~bus.rx_data[7];                    // 00-7F
  assign is_chan_status = bus.rx_data[7] & ~(&bus.rx_data[7:4]); // 80-EF
  assign is_f0          = (bus.rx_data == 8'hF0);
  assign is_f7          = (bus.rx_data == 8'hF7);

  // Note off/on, poly aftertouch, control change and pitch bend carry two
  // data bytes; program change and channel pressure carry one.
  always_comb begin
    case (status_q[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: two_data = 1'b1;
      default:                      two_data = 1'b0;
    endcase
  end

  assign nr_sat_inc = (nr_q == SYX_MAX_NR) ? SYX_MAX_NR : nr_q + 8'd1;

  // NOTE: every variable gets its default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    byteready_d = 1'b0;
    nr_d        = nr_q;
    data_d      = data_q;
    ch_d        = ch_q;
    cur_d       = cur_q;
    sysex_d     = sysex_q;
    status_d    = status_q;
    rt_valid_d  = 1'b0;
    rt_byte_d   = rt_byte_q;
    drop_d      = drop_q;
    sysex_end_d = 1'b0;

    // Deferred close of sysex; a byte accepted this cycle overrides it below.
    if (sysex_end_q) sysex_d = 1'b0;

    if (bus.rx_valid) begin
      if (is_rt) begin
        // Real-time bytes interleave anywhere without disturbing the message.
        rt_valid_d = 1'b1;
        rt_byte_d  = bus.rx_data;
      end else if (is_data) begin
        case (state_q)
          CHAN: begin
            byteready_d = 1'b1;
            data_d      = bus.rx_data;
            if (two_data) nr_d = (nr_q == NR_WRAP) ? 8'd1 : nr_q + 8'd1;
            else          nr_d = 8'd1;
          end
          SYSEX: begin
            byteready_d = 1'b1;
            data_d      = bus.rx_data;
            nr_d        = nr_sat_inc;
          end
          default: begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
        endcase
      end else if (is_chan_status) begin
        state_d     = CHAN;
        status_d    = bus.rx_data;
        ch_d        = bus.rx_data[3:0];
        cur_d       = bus.omni | (bus.rx_data[3:0] == bus.sel_midi_ch);
        nr_d        = 8'd0;
        byteready_d = 1'b1;
        data_d      = bus.rx_data;
        sysex_d     = 1'b0;
      end else if (is_f0) begin
        state_d     = SYSEX;
        status_d    = 8'd0;
        cur_d       = 1'b0;
        nr_d        = 8'd0;
        byteready_d = 1'b1;
        data_d      = bus.rx_data;
        sysex_d     = 1'b1;
      end else if (is_f7) begin
        state_d  = IDLE;
        status_d = 8'd0;
        if (state_q == SYSEX) begin
          byteready_d = 1'b1;
          data_d      = bus.rx_data;
          nr_d        = nr_sat_inc;
          sysex_d     = 1'b1;
          sysex_end_d = 1'b1;
        end
      end else begin
        // F1-F6: system common, its data bytes are not forwarded.
        state_d  = COMMON;
        status_d = 8'd0;
        sysex_d  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state_q     <= IDLE;
      byteready_q <= 1'b0;
      nr_q        <= 8'd0;
      data_q      <= 8'd0;
      ch_q        <= 4'd0;
      cur_q       <= 1'b0;
      sysex_q     <= 1'b0;
      status_q    <= 8'd0;
      rt_valid_q  <= 1'b0;
      rt_byte_q   <= 8'd0;
      drop_q      <= 8'd0;
      sysex_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteready_q <= byteready_d;
      nr_q        <= nr_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      cur_q       <= cur_d;
      sysex_q     <= sysex_d;
      status_q    <= status_d;
      rt_valid_q  <= rt_valid_d;
      rt_byte_q   <= rt_byte_d;
      drop_q      <= drop_d;
      sysex_end_q <= sysex_end_d;
    end
  end

  assign bus.byteready      = byteready_q;
  assign bus.midibyte_nr    = nr_q;
  assign bus.midi_in_data   = data_q;
  assign bus.midi_ch        = ch_q;
  assign bus.is_cur_midi_ch = cur_q;
  assign bus.is_st_sysex    = sysex_q;
  assign bus.status_byte    = status_q;
  assign bus.rt_valid       = rt_valid_q;
  assign bus.rt_byte        = rt_byte_q;
  assign bus.drop_cnt       = drop_q;

endmodule

// File: tb/tb_midi_byte_decoder.sv
// -----------------------------------------------------------------------------
// tb_midi_byte_decoder
//
// Directed stimulus for midi_byte_decoder. A message-level model predicts the
// outputs for every cycle; a compare process checks them on each negedge, and
// hand-computed literals at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_midi_byte_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  midi_byte_decoder_if bus ();

  midi_byte_decoder dut (
    .reg_clk   (clk),
    .reset_reg (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: message-level view. A non-zero running status means channel data is
  // accepted; m_sysex means sysex data is accepted; otherwise data is dropped.
  // m_cnt counts data bytes since the last status/F0.
  // ---------------------------------------------------------------------------
  logic [7:0] m_status;
  logic       m_sysex;
  int         m_cnt;
  int         m_drop;
  logic       m_close;

  logic       exp_byteready, exp_cur, exp_sysex, exp_rt_valid;
  logic [7:0] exp_nr, exp_data, exp_rt_byte;
  logic [3:0] exp_ch;

  function automatic logic has_two_data(input logic [7:0] st);
    int hi;
    hi = int'(st) / 16;
    return (hi == 8 || hi == 9 || hi == 10 || hi == 11 || hi == 14);
  endfunction

  function automatic logic [7:0] sat255(input int v);
    return (v > 255) ? 8'd255 : v[7:0];
  endfunction

  task automatic model_reset();
    m_status = 0; m_sysex = 0; m_cnt = 0; m_drop = 0; m_close = 0;
    exp_byteready = 0; exp_cur = 0; exp_sysex = 0; exp_rt_valid = 0;
    exp_nr = 0; exp_data = 0; exp_rt_byte = 0; exp_ch = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int nr2;
    exp_byteready = 0;
    exp_rt_valid  = 0;
    if (m_close) begin
      exp_sysex = 0;
      m_close   = 0;
    end
    if (v) begin
      if (b >= 8'hF8) begin
        exp_rt_valid = 1;
        exp_rt_byte  = b;
      end else if (b < 8'h80) begin
        if (m_status != 0) begin
          m_cnt++;
          nr2 = ((m_cnt - 1) % 254) + 1;
          exp_nr = has_two_data(m_status) ? nr2[7:0] : 8'd1;
          exp_byteready = 1; exp_data = b;
        end else if (m_sysex) begin
          m_cnt++;
          exp_nr = sat255(m_cnt);
          exp_byteready = 1; exp_data = b;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end else if (b < 8'hF0) begin
        m_status = b; m_sysex = 0; m_cnt = 0;
        exp_ch  = b[3:0];
        exp_cur = bus.omni | (b[3:0] == bus.sel_midi_ch);
        exp_sysex = 0; exp_nr = 0;
        exp_byteready = 1; exp_data = b;
      end else if (b == 8'hF0) begin
        m_status = 0; m_sysex = 1; m_cnt = 0;
        exp_sysex = 1; exp_cur = 0; exp_nr = 0;
        exp_byteready = 1; exp_data = b;
      end else if (b == 8'hF7) begin
        if (m_sysex) begin
          m_cnt++;
          exp_nr = sat255(m_cnt);
          exp_byteready = 1; exp_data = b;
          m_close = 1;
        end
        m_status = 0; m_sysex = 0;
      end else begin
        m_status = 0; m_sysex = 0; exp_sysex = 0;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step(bus.rx_valid, bus.rx_data);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("byteready",      32'(bus.byteready),      32'(exp_byteready));
    check("midibyte_nr",    32'(bus.midibyte_nr),    32'(exp_nr));
    check("midi_in_data",   32'(bus.midi_in_data),   32'(exp_data));
    check("midi_ch",        32'(bus.midi_ch),        32'(exp_ch));
    check("is_cur_midi_ch", 32'(bus.is_cur_midi_ch), 32'(exp_cur));
    check("is_st_sysex",    32'(bus.is_st_sysex),    32'(exp_sysex));
    check("status_byte",    32'(bus.status_byte),    32'(m_status));
    check("rt_valid",       32'(bus.rt_valid),       32'(exp_rt_valid));
    check("rt_byte",        32'(bus.rt_byte),        32'(exp_rt_byte));
    check("drop_cnt",       32'(bus.drop_cnt),       32'(m_drop));
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Tasks start and end 1 time unit after a posedge; after send()
  // the outputs produced by that byte are visible.
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic lit_byte(input string name, input logic [7:0] nr,
                          input logic [7:0] data);
    check({name, ".byteready"}, 32'(bus.byteready), 32'd1);
    check({name, ".nr"},        32'(bus.midibyte_nr), 32'(nr));
    check({name, ".data"},      32'(bus.midi_in_data), 32'(data));
  endtask

  initial begin
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.sel_midi_ch = 4'd0;
    bus.omni        = 1'b0;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst.byteready", 32'(bus.byteready), 32'd0);
    check("rst.status",    32'(bus.status_byte), 32'd0);
    check("rst.drop",      32'(bus.drop_cnt), 32'd0);

    // 1: note on, channel 0
    send(8'h90); lit_byte("t1.s", 8'd0, 8'h90);
    check("t1.ch",  32'(bus.midi_ch), 32'd0);
    check("t1.cur", 32'(bus.is_cur_midi_ch), 32'd1);
    send(8'h3C); lit_byte("t1.d1", 8'd1, 8'h3C);
    send(8'h64); lit_byte("t1.d2", 8'd2, 8'h64);
    check("t1.cur2", 32'(bus.is_cur_midi_ch), 32'd1);
    idle(1);
    check("t1.idle", 32'(bus.byteready), 32'd0);

    // 2: running status on channel 1, not selected, then omni
    send(8'h91);
    check("t2.cur", 32'(bus.is_cur_midi_ch), 32'd0);
    check("t2.ch",  32'(bus.midi_ch), 32'd1);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h40);
    lit_byte("t2.d4", 8'd4, 8'h40);
    bus.omni = 1'b1;
    send(8'h91);
    check("t2.omni", 32'(bus.is_cur_midi_ch), 32'd1);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h40);
    lit_byte("t2.od4", 8'd4, 8'h40);
    bus.omni = 1'b0;

    // 3: sysex then channel message
    send(8'hF0);
    check("t3.sx0", 32'(bus.is_st_sysex), 32'd1);
    check("t3.cur", 32'(bus.is_cur_midi_ch), 32'd0);
    send(8'h43); send(8'h10);
    send(8'hF7); lit_byte("t3.f7", 8'd3, 8'hF7);
    check("t3.sxf7", 32'(bus.is_st_sysex), 32'd1);
    idle(1);
    check("t3.sxclr", 32'(bus.is_st_sysex), 32'd0);
    send(8'h80); send(8'h3C); send(8'h00);
    lit_byte("t3.ch2", 8'd2, 8'h00);
    check("t3.status", 32'(bus.status_byte), 32'h80);

    // 4: real-time interleaved
    send(8'h90); send(8'h3C);
    send(8'hF8);
    check("t4.rtv", 32'(bus.rt_valid), 32'd1);
    check("t4.rtb", 32'(bus.rt_byte), 32'hF8);
    check("t4.nobr", 32'(bus.byteready), 32'd0);
    check("t4.nr", 32'(bus.midibyte_nr), 32'd1);
    send(8'h64); lit_byte("t4.d2", 8'd2, 8'h64);
    check("t4.rtoff", 32'(bus.rt_valid), 32'd0);

    // 5: drops after reset and in system common
    pulse_reset();
    send(8'h3C); send(8'h64); send(8'hF2); send(8'h10);
    check("t5.nobr", 32'(bus.byteready), 32'd0);
    check("t5.drop", 32'(bus.drop_cnt), 32'd3);
    check("t5.status", 32'(bus.status_byte), 32'd0);

    // 6: reset mid-sysex, takes effect without a clock edge
    send(8'hF0); send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    #1;
    check("t6.br",   32'(bus.byteready), 32'd0);
    check("t6.nr",   32'(bus.midibyte_nr), 32'd0);
    check("t6.data", 32'(bus.midi_in_data), 32'd0);
    check("t6.sx",   32'(bus.is_st_sysex), 32'd0);
    check("t6.drop", 32'(bus.drop_cnt), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h44); send(8'h55);
    check("t6.nobr", 32'(bus.byteready), 32'd0);
    check("t6.drop2", 32'(bus.drop_cnt), 32'd2);
    send(8'h92); lit_byte("t6.new", 8'd0, 8'h92);

    // F7 close coinciding with a new F0
    send(8'hF0); send(8'h01); send(8'hF7); send(8'hF0);
    check("cl.sx", 32'(bus.is_st_sysex), 32'd1);
    lit_byte("cl.f0", 8'd0, 8'hF0);
    send(8'hF7); idle(1);

    // 1-data running status stays at 1
    send(8'hC3); send(8'h05); send(8'h06); send(8'h07);
    lit_byte("pc.d", 8'd1, 8'h07);

    // 2-data wrap after NR_WRAP
    send(8'hB0);
    for (int i = 1; i <= 256; i++) begin
      send(8'(i % 128));
      if (i == 254) check("wrap.254", 32'(bus.midibyte_nr), 32'd254);
      if (i == 255) check("wrap.255", 32'(bus.midibyte_nr), 32'd1);
      if (i == 256) check("wrap.256", 32'(bus.midibyte_nr), 32'd2);
    end

    // Sysex counter saturation
    send(8'hF0);
    for (int i = 1; i <= 257; i++) send(8'h7F);
    check("sxsat", 32'(bus.midibyte_nr), 32'd255);
    send(8'hF7);
    check("sxsat.f7", 32'(bus.midibyte_nr), 32'd255);
    idle(1);

    // drop_cnt saturation
    pulse_reset();
    for (int i = 0; i < 260; i++) send(8'h12);
    check("dropsat", 32'(bus.drop_cnt), 32'd255);

    // Outside-sysex F7 clears running status
    send(8'h95); send(8'hF7);
    check("f7.status", 32'(bus.status_byte), 32'd0);
    send(8'h20);
    check("f7.drop", 32'(bus.byteready), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_byte_decoder.md
Name: midi_byte_decoder

Overview:
- Upstream neighbour of the synth-controller sequence trigger stage.
- Takes raw MIDI bytes from the UART receiver and tracks status and running status.
- Numbers each byte within its message and tags channel/sysex context.
- Emits a registered byte stream (byteready, midibyte_nr, midi_in_data, midi_ch, is_cur_midi_ch, is_st_sysex) that the trigger stage consumes directly.

Parameters:
- SYX_MAX_NR, 255: saturation value of midibyte_nr during sysex.
- NR_WRAP, 254: last midibyte_nr in 2-data-byte running status; next data byte takes 1.

Ports:
- reg_clk  in  1  system register clock.
- reset_reg  in  1  asynchronous, active-high reset.
- rx_data  in  8  received MIDI byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid. May assert on consecutive cycles.
- sel_midi_ch  in  4  channel this synth listens on.
- omni  in  1  1 = accept every channel.
- byteready  out  1  one-cycle pulse per accepted byte.
- midibyte_nr  out  8  position of byte in message (status = 0).
- midi_in_data  out  8  accepted byte.
- midi_ch  out  4  channel of current channel-voice status.
- is_cur_midi_ch  out  1  current message is for this synth.
- is_st_sysex  out  1  inside a sysex message.
- status_byte  out  8  latched running status (0 = none).
- rt_valid  out  1  one-cycle pulse for a real-time byte (F8-FF).
- rt_byte  out  8  the real-time byte.
- drop_cnt  out  8  count of discarded data bytes, saturates at 255.

Behaviour:
- Clocking and reset
  - Single clock reg_clk.
  - reset_reg is asynchronous, active-high; it clears every register immediately, including mid-sysex or mid-message.
  - Reset values: all outputs 0; state IDLE.
- Latency and output timing
  - Registered outputs; latency 1: rx_valid at cycle N gives byteready/rt_valid at N+1.
  - midibyte_nr, midi_in_data, midi_ch, is_cur_midi_ch and is_st_sysex update together with byteready.
  - They hold until the next accepted byte.
- State machine
  - States: IDLE (no running status), CHAN (channel-voice running status), SYSEX, COMMON (system common, discarding).
  - Byte classes: real-time F8-FF; status 80-F7; data 00-7F.
- Real-time bytes (any state)
  - rt_valid pulse with rt_byte = byte.
  - No byteready, no state change, midibyte_nr untouched.
- Status 80-EF (any state; also implicitly ends sysex)
  - State becomes CHAN; status_byte = byte; midi_ch = byte[3:0]; midibyte_nr = 0.
  - byteready pulses; midi_in_data = byte; is_st_sysex = 0.
  - is_cur_midi_ch = omni | (byte[3:0] == sel_midi_ch).
- Data byte in CHAN
  - byteready pulses.
  - 2-data messages (8x, 9x, Ax, Bx, Ex): midibyte_nr increments 1, 2, 3, …; after NR_WRAP the next data byte is 1, so parity stays odd = first data byte, even = second.
  - 1-data messages (Cx, Dx): midibyte_nr = 1 for every data byte.
- F0 (any state)
  - State becomes SYSEX; is_st_sysex = 1; is_cur_midi_ch = 0; status_byte = 0; midibyte_nr = 0.
  - byteready pulses with data F0.
- Data byte in SYSEX
  - byteready pulses; midibyte_nr increments, saturating at SYX_MAX_NR.
- F7
  - In SYSEX: byteready pulses with data F7, midibyte_nr incremented (saturating), is_st_sysex still 1 on that pulse.
  - Next cycle: is_st_sysex = 0, state becomes IDLE.
  - F7 outside SYSEX: ignored except it clears running status (state IDLE).
- F1-F6 (any state)
  - State becomes COMMON; status_byte = 0; no byteready.
  - is_st_sysex cleared if it was set.
- Discarded data
  - Data bytes in IDLE or COMMON: no byteready; drop_cnt increments, saturating at 255.
- Simultaneous events
  - Only one rx byte per cycle.
  - If an F7 deassert of is_st_sysex coincides with a new accepted byte, the new byte's classification wins.

Test Plan:
1. 90 3C 64 with sel_midi_ch=0 → byteready ×3; midibyte_nr 0, 1, 2; midi_ch=0; is_cur_midi_ch=1 on each; data echoed with latency 1.
2. Running status: 91 3C 64 3E 40 with sel_midi_ch=0, omni=0 → midibyte_nr 0, 1, 2, 3, 4; is_cur_midi_ch=0. Repeat with omni=1 → is_cur_midi_ch=1.
3. F0 43 10 F7, then 80 3C 00 → is_st_sysex=1 on pulses with nr 0, 1, 2, 3; cleared the cycle after F7; then channel message with nr 0, 1, 2.
4. 90 3C F8 64 → rt_valid with rt_byte=F8 between the data bytes; midibyte_nr 1 then 2 unaffected.
5. After reset, send 3C 64, then F2 10 → no byteready; drop_cnt=3; status_byte=0.
6. Assert reset_reg mid-sysex after 3 data bytes → all outputs 0 at once; following data bytes are dropped until a new status byte.
